univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register: the successor to the fixed 4-bit serial-in/parallel-out shifter. Adds configurable width, bidirectional shift, rotate, arithmetic shift, parallel load and clear, and a shift counter with a frame-complete pulse. It sits between serial links and parallel datapaths as a SIPO, PISO, SISO or PIPO element, selected per cycle by `mode`.

## Interface
- `WIDTH`, default 4: register width in bits; legal range 2..64.
- `RESET_VAL`, default 0: value loaded into `pout` by `reset`.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset. It overrides every other input.
- `en` in 1: operation enable. When 0, the block behaves as mode HOLD.
- `mode` in 3: operation select, listed under Operation.
- `sin_l` in 1: serial input. Enters bit 0 on SHL.
- `sin_r` in 1: serial input. Enters bit WIDTH-1 on SHR.
- `pin` in WIDTH: parallel load data.
- `pout` out WIDTH: register contents.
- `sout_l` out 1: equals `pout[WIDTH-1]`. Combinational from the register.
- `sout_r` out 1: equals `pout[0]`. Combinational from the register.
- `cnt` out $clog2(WIDTH+1): number of shift-class operations since the last reset, LOAD or CLR.
- `frame_done` out 1: one-cycle pulse when the WIDTH-th shift-class operation completes.

## Operation
Modes, with R = `pout`:
- 000 HOLD: R unchanged.
- 001 SHL: R <= {R[WIDTH-2:0], sin_l}.
- 010 SHR: R <= {sin_r, R[WIDTH-1:1]}.
- 011 ROL: R <= {R[WIDTH-2:0], R[WIDTH-1]}.
- 100 ROR: R <= {R[0], R[WIDTH-1:1]}.
- 101 LOAD: R <= pin.
- 110 CLR: R <= 0. CLR always loads 0, not RESET_VAL.
- 111 ASR: R <= {R[WIDTH-1], R[WIDTH-1:1]}; the MSB is replicated.

Shift-class modes are SHL, SHR, ROL, ROR and ASR.

Counter:
- Each shift-class operation with `en`=1: if `cnt`==WIDTH-1, then `cnt` <= 0 and `frame_done` <= 1. Otherwise `cnt` <= `cnt`+1 and `frame_done` <= 0.
- LOAD or CLR: `cnt` <= 0 and `frame_done` <= 0.
- HOLD or `en`=0: `cnt` unchanged and `frame_done` <= 0.
- `cnt` never reaches WIDTH. Wrap-around is exact and gapless: shifting continuously for 2*WIDTH cycles produces exactly two `frame_done` pulses, WIDTH cycles apart.
- Mixing directions does not reset `cnt`. For example, SHL then SHR counts as 2.

Reset:
- `pout` = RESET_VAL, `cnt` = 0, `frame_done` = 0.
- `sout_l` and `sout_r` follow `pout` accordingly.
- Reset asserted mid-frame discards the partial count.

## Timing
- All modes take effect at the rising edge where they are sampled. `pout` shows the result one cycle after `mode` and `en` are presented.
- `frame_done` is registered. It is high during the cycle immediately after the edge that performed the WIDTH-th shift, when `pout` already holds the complete frame. It is never high for two consecutive cycles unless WIDTH shifts complete on consecutive edges, which requires WIDTH==1 and is therefore impossible.
- `sout_l` and `sout_r` have zero latency relative to `pout` and carry no combinational path from any input.
- If `reset` and `en`/`mode` are active on the same edge, reset wins.
- LOAD on the same edge as a would-be final shift: LOAD wins. `frame_done` stays 0 and `cnt` = 0.
- Inputs `sin_l`, `sin_r` and `pin` are sampled only in the modes that use them. Their values in any other mode must not affect state.
- No handshake. The upstream side must hold `en`/`mode` for exactly the number of cycles it intends to act.

## Test plan
1. SIPO, WIDTH=4: reset, then SHL with `sin_l` = 1,0,0,0 on four edges.
   - Required: `pout` = 0001, 0010, 0100, 1000.
   - Required: `cnt` = 1, 2, 3, 0.
   - Required: `frame_done` = 1 only after the 4th edge.
   - Required: `sout_l` = 1 after the 4th edge.
2. PISO, WIDTH=4: LOAD `pin`=1011, then SHR with `sin_r`=0 for four cycles.
   - Required: `sout_r` sequence = 1, 1, 0, 1.
   - Required: final `pout` = 0000.
   - Required: `frame_done` pulses once.
3. Rotate and ASR, WIDTH=8: LOAD 0x81.
   - ROL gives 0x03.
   - ROR twice gives 0xC0.
   - ASR gives 0xE0.
   - Eight ROL operations from 0x81 return 0x81 with exactly one `frame_done` pulse.
4. Enable and hold: during a SHL frame, deassert `en` for 3 cycles after 2 shifts.
   - Required: `pout` and `cnt`=2 stay frozen.
   - Required: `frame_done` appears only after 2 further shifts.
5. Reset and priority, WIDTH=4, RESET_VAL=4'b1010:
   - Reset asserted after 3 shifts with `en`=1, mode=SHL: gives `pout`=1010, `cnt`=0, `frame_done`=0.
   - LOAD issued on what would be the 4th shift: gives `cnt`=0 and no `frame_done` pulse.
   - CLR: gives `pout`=0000.
6. Continuous streaming: 2*WIDTH back-to-back SHL operations with random `sin_l`.
   - Required: `pout` equals a reference model every cycle.
   - Required: exactly 2 `frame_done` pulses, WIDTH cycles apart.

Source files
------------

// File: rtl/univ_shift_reg.sv
// univ_shift_reg -- parametrised universal shift register.
//   Per-cycle mode select covers hold, logical shift left/right, rotate
//   left/right, arithmetic shift right, parallel load and clear. A shift
//   counter tracks shift-class operations and pulses o_frame_done when the
//   WIDTH-th one completes.
// Ports:
//   i_clk         clock, all state updates on rising edge
//   i_reset       synchronous active-high reset, overrides everything
//   i_en          operation enable (0 behaves as HOLD)
//   i_mode[2:0]   operation select
//   i_sin_l       serial in, enters bit 0 on SHL
//   i_sin_r       serial in, enters bit WIDTH-1 on SHR
//   i_pin         parallel load data
//   o_pout        register contents
//   o_sout_l      o_pout[WIDTH-1]
//   o_sout_r      o_pout[0]
//   o_cnt         shift-class operations since last reset/LOAD/CLR, mod WIDTH
//   o_frame_done  registered one-cycle pulse after the WIDTH-th shift
module univ_shift_reg #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int             CW        = $clog2(WIDTH+1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  input  logic [WIDTH-1:0] i_pin,
  output logic [WIDTH-1:0] o_pout,
  output logic             o_sout_l,
  output logic             o_sout_r,
  output logic [CW-1:0]    o_cnt,
  output logic             o_frame_done
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHL  = 3'b001,
    M_SHR  = 3'b010,
    M_ROL  = 3'b011,
    M_ROR  = 3'b100,
    M_LOAD = 3'b101,
    M_CLR  = 3'b110,
    M_ASR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] r_pout;
  logic [CW-1:0]    r_cnt;
  logic             r_frame_done;

  logic [WIDTH-1:0] w_next;
  logic             w_shift;   // shift-class op this cycle
  logic             w_restart; // LOAD/CLR restart the frame
  mode_e            w_mode;

  // en=0 collapses to HOLD so no other path needs to look at i_en
  assign w_mode = i_en ? mode_e'(i_mode) : M_HOLD;

  always_comb begin
    w_next    = r_pout;
    w_shift   = 1'b0;
    w_restart = 1'b0;
    unique case (w_mode)
      M_HOLD: w_next = r_pout;
      M_SHL:  begin w_next = {r_pout[WIDTH-2:0], i_sin_l};      w_shift = 1'b1; end
      M_SHR:  begin w_next = {i_sin_r, r_pout[WIDTH-1:1]};      w_shift = 1'b1; end
      M_ROL:  begin w_next = {r_pout[WIDTH-2:0], r_pout[WIDTH-1]}; w_shift = 1'b1; end
      M_ROR:  begin w_next = {r_pout[0], r_pout[WIDTH-1:1]};    w_shift = 1'b1; end
      M_LOAD: begin w_next = i_pin;                             w_restart = 1'b1; end
      M_CLR:  begin w_next = '0;                                w_restart = 1'b1; end
      M_ASR:  begin w_next = {r_pout[WIDTH-1], r_pout[WIDTH-1:1]}; w_shift = 1'b1; end
      default: w_next = r_pout;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pout       <= RESET_VAL;
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_pout <= w_next;
      if (w_restart) begin
        r_cnt        <= '0;
        r_frame_done <= 1'b0;
      end else if (w_shift) begin
        // wrap on the WIDTH-th shift so the next frame starts gaplessly
        if (r_cnt == CW'(WIDTH-1)) begin
          r_cnt        <= '0;
          r_frame_done <= 1'b1;
        end else begin
          r_cnt        <= r_cnt + CW'(1);
          r_frame_done <= 1'b0;
        end
      end else begin
        r_frame_done <= 1'b0;
      end
    end
  end

  assign o_pout       = r_pout;
  assign o_sout_l     = r_pout[WIDTH-1];
  assign o_sout_r     = r_pout[0];
  assign o_cnt        = r_cnt;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg. Three instances share one input set:
// ua (WIDTH=4, RESET_VAL=0), ub (WIDTH=4, RESET_VAL=1010), uc (WIDTH=8).
module tb_univ_shift_reg;
  localparam logic [2:0] HOLD = 3'b000, SHL = 3'b001, SHR = 3'b010, ROL = 3'b011,
                         ROR = 3'b100, LOAD = 3'b101, CLR = 3'b110, ASR = 3'b111;

  logic       clk = 1'b0;
  logic       reset, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [7:0] pin;

  logic [3:0] a_pout, b_pout;
  logic [7:0] c_pout;
  logic       a_sl, a_sr, b_sl, b_sr, c_sl, c_sr;
  logic [2:0] a_cnt, b_cnt;
  logic [3:0] c_cnt;
  logic       a_fd, b_fd, c_fd;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b0000)) ua (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_mode(mode), .i_sin_l(sin_l),
    .i_sin_r(sin_r), .i_pin(pin[3:0]), .o_pout(a_pout), .o_sout_l(a_sl),
    .o_sout_r(a_sr), .o_cnt(a_cnt), .o_frame_done(a_fd));

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'b1010)) ub (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_mode(mode), .i_sin_l(sin_l),
    .i_sin_r(sin_r), .i_pin(pin[3:0]), .o_pout(b_pout), .o_sout_l(b_sl),
    .o_sout_r(b_sr), .o_cnt(b_cnt), .o_frame_done(b_fd));

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) uc (
    .i_clk(clk), .i_reset(reset), .i_en(en), .i_mode(mode), .i_sin_l(sin_l),
    .i_sin_r(sin_r), .i_pin(pin), .o_pout(c_pout), .o_sout_l(c_sl),
    .o_sout_r(c_sr), .o_cnt(c_cnt), .o_frame_done(c_fd));

  // apply current inputs on one rising edge, settle 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] m, input logic sl, input logic sr, input logic [7:0] p);
    en = 1'b1; mode = m; sin_l = sl; sin_r = sr; pin = p;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; mode = SHL; sin_l = 1'b1; sin_r = 1'b1; pin = 8'hFF;
    tick();
    n_vec++;
    if (a_pout !== 4'b0000 || a_cnt !== 3'd0 || a_fd !== 1'b0) begin
      n_err++; $display("FAIL reset_a: pout=%b cnt=%0d fd=%b, want 0000 0 0", a_pout, a_cnt, a_fd);
    end
    n_vec++;
    if (b_pout !== 4'b1010 || b_sl !== 1'b1 || b_sr !== 1'b0 || b_cnt !== 3'd0) begin
      n_err++; $display("FAIL reset_b: pout=%b sl=%b sr=%b cnt=%0d, want 1010 1 0 0", b_pout, b_sl, b_sr, b_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_sipo();
    logic [3:0] exp_p [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [2:0] exp_c [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    logic       exp_f [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      op(SHL, (i == 0), 1'b1, 8'hFF);
      n_vec++;
      if (a_pout !== exp_p[i] || a_cnt !== exp_c[i] || a_fd !== exp_f[i]) begin
        n_err++; $display("FAIL sipo[%0d]: pout=%b cnt=%0d fd=%b, want %b %0d %b",
                          i, a_pout, a_cnt, a_fd, exp_p[i], exp_c[i], exp_f[i]);
      end
    end
    n_vec++;
    if (a_sl !== 1'b1) begin n_err++; $display("FAIL sipo_sout_l: got %b want 1", a_sl); end
  endtask

  task automatic test_piso();
    logic exp_sr [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    int   pulses = 0;
    op(LOAD, 1'b1, 1'b1, 8'h0B);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (a_sr !== exp_sr[i]) begin
        n_err++; $display("FAIL piso_sout_r[%0d]: got %b want %b", i, a_sr, exp_sr[i]);
      end
      op(SHR, 1'b1, 1'b0, 8'hFF);
      if (a_fd === 1'b1) pulses++;
    end
    n_vec++;
    if (a_pout !== 4'b0000 || pulses != 1) begin
      n_err++; $display("FAIL piso_end: pout=%b pulses=%0d, want 0000 1", a_pout, pulses);
    end
  endtask

  task automatic test_rotate_asr();
    int pulses = 0;
    op(LOAD, 1'b0, 1'b0, 8'h81);
    op(ROL, 1'b0, 1'b0, 8'h00);
    n_vec++;
    if (c_pout !== 8'h03) begin n_err++; $display("FAIL rol: got %h want 03", c_pout); end
    op(ROR, 1'b1, 1'b1, 8'h00);
    op(ROR, 1'b1, 1'b1, 8'h00);
    n_vec++;
    if (c_pout !== 8'hC0) begin n_err++; $display("FAIL ror2: got %h want c0", c_pout); end
    op(ASR, 1'b0, 1'b0, 8'h00);
    n_vec++;
    if (c_pout !== 8'hE0 || c_cnt !== 4'd4) begin
      n_err++; $display("FAIL asr: pout=%h cnt=%0d want e0 4", c_pout, c_cnt);
    end
    op(LOAD, 1'b0, 1'b0, 8'h81);
    for (int i = 0; i < 8; i++) begin
      op(ROL, 1'b0, 1'b0, 8'h00);
      if (c_fd === 1'b1) pulses++;
    end
    n_vec++;
    if (c_pout !== 8'h81 || pulses != 1 || c_fd !== 1'b1) begin
      n_err++; $display("FAIL rol8: pout=%h pulses=%0d fd=%b want 81 1 1", c_pout, pulses, c_fd);
    end
  endtask

  task automatic test_enable_hold();
    op(CLR, 1'b0, 1'b0, 8'h00);
    op(SHL, 1'b1, 1'b0, 8'h00);
    op(SHL, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      en = 1'b0; mode = (i == 1) ? LOAD : SHL; sin_l = 1'b0; pin = 8'h05;
      tick();
      n_vec++;
      if (a_pout !== 4'b0011 || a_cnt !== 3'd2 || a_fd !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d]: pout=%b cnt=%0d fd=%b want 0011 2 0", i, a_pout, a_cnt, a_fd);
      end
    end
    op(SHL, 1'b0, 1'b0, 8'h00);
    n_vec++;
    if (a_pout !== 4'b0110 || a_cnt !== 3'd3 || a_fd !== 1'b0) begin
      n_err++; $display("FAIL hold_resume3: pout=%b cnt=%0d fd=%b want 0110 3 0", a_pout, a_cnt, a_fd);
    end
    op(SHL, 1'b0, 1'b0, 8'h00);
    n_vec++;
    if (a_pout !== 4'b1100 || a_cnt !== 3'd0 || a_fd !== 1'b1) begin
      n_err++; $display("FAIL hold_resume4: pout=%b cnt=%0d fd=%b want 1100 0 1", a_pout, a_cnt, a_fd);
    end
    // HOLD ignores serial/parallel inputs and drops the pulse
    op(HOLD, 1'b1, 1'b1, 8'h0F);
    n_vec++;
    if (a_pout !== 4'b1100 || a_fd !== 1'b0) begin
      n_err++; $display("FAIL hold_mode: pout=%b fd=%b want 1100 0", a_pout, a_fd);
    end
    // mixed directions keep counting
    op(SHL, 1'b1, 1'b0, 8'h00);
    op(SHR, 1'b0, 1'b1, 8'h00);
    n_vec++;
    if (a_pout !== 4'b1100 || a_cnt !== 3'd2) begin
      n_err++; $display("FAIL mixed_dir: pout=%b cnt=%0d want 1100 2", a_pout, a_cnt);
    end
  endtask

  task automatic test_reset_priority();
    op(CLR, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) op(SHL, 1'b1, 1'b0, 8'h00);
    reset = 1'b1; en = 1'b1; mode = SHL; sin_l = 1'b1;
    tick();
    reset = 1'b0;
    n_vec++;
    if (b_pout !== 4'b1010 || b_cnt !== 3'd0 || b_fd !== 1'b0) begin
      n_err++; $display("FAIL reset_mid: pout=%b cnt=%0d fd=%b want 1010 0 0", b_pout, b_cnt, b_fd);
    end
    for (int i = 0; i < 3; i++) op(SHL, 1'b0, 1'b0, 8'h00);
    n_vec++;
    if (b_pout !== 4'b0000 || b_cnt !== 3'd3) begin
      n_err++; $display("FAIL pre_load: pout=%b cnt=%0d want 0000 3", b_pout, b_cnt);
    end
    op(LOAD, 1'b1, 1'b1, 8'h06);
    n_vec++;
    if (b_pout !== 4'b0110 || b_cnt !== 3'd0 || b_fd !== 1'b0) begin
      n_err++; $display("FAIL load_wins: pout=%b cnt=%0d fd=%b want 0110 0 0", b_pout, b_cnt, b_fd);
    end
    op(HOLD, 1'b0, 1'b0, 8'h00);
    n_vec++;
    if (b_fd !== 1'b0 || b_cnt !== 3'd0) begin
      n_err++; $display("FAIL load_nopulse: fd=%b cnt=%0d want 0 0", b_fd, b_cnt);
    end
    op(CLR, 1'b1, 1'b1, 8'hFF);
    n_vec++;
    if (b_pout !== 4'b0000) begin n_err++; $display("FAIL clr: got %b want 0000", b_pout); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ref_p = 8'h00;
    int         pulse_at [$];
    logic       b;
    op(CLR, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      b = 1'($urandom_range(1, 0));
      op(SHL, b, 1'b0, 8'h00);
      ref_p = {ref_p[6:0], b};
      n_vec++;
      if (c_pout !== ref_p) begin
        n_err++; $display("FAIL stream[%0d]: got %h want %h", i, c_pout, ref_p);
      end
      if (c_fd === 1'b1) pulse_at.push_back(i);
    end
    n_vec++;
    if (pulse_at.size() != 2) begin
      n_err++; $display("FAIL stream_pulses: got %0d want 2", pulse_at.size());
    end else if (pulse_at[0] != 7 || pulse_at[1] != 15) begin
      n_err++; $display("FAIL stream_spacing: pulses at %0d,%0d want 7,15", pulse_at[0], pulse_at[1]);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = HOLD; sin_l = 1'b0; sin_r = 1'b0; pin = '0;
    test_reset();
    test_sipo();
    test_piso();
    test_rotate_asr();
    test_enable_hold();
    test_reset_priority();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
